hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core. Produces Execute-stage operand forwarding selects, load-use stall, and branch/jump flush.
- Sequences multi-cycle operations (multiply/divide) occupying Execute via a small FSM, with watchdog and stall/flush performance counters.
- Sits beside the F/D/E/M/W pipeline registers and drives their enable/clear inputs.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: E-stage forwarding, load-use stall,
// branch flush, multi-cycle op sequencing with watchdog, and stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MduStartE,
  input  logic             MduDoneE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MduBusy,
  output logic             MduTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int BC_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_LIMIT = BC_W'(MDU_TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [BC_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic             mdu_hold;

  // M stage wins over W; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    mdu_hold   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_cnt_d = '0;
        if (MduStartE) begin
          state_d  = BUSY;
          mdu_hold = 1'b1;
        end
      end
      BUSY: begin
        if (MduDoneE) begin
          state_d    = IDLE;
          busy_cnt_d = '0;
        end else begin
          mdu_hold = 1'b1;
          // Counter parks at the limit; the flag is sticky so it cannot re-arm.
          if (busy_cnt_q != BC_LIMIT) busy_cnt_d = busy_cnt_q + BC_W'(1);
          if (busy_cnt_d == BC_LIMIT) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The op in E is the MDU instruction while held, so branch resolution is masked.
  assign StallF = lw_stall || mdu_hold;
  assign StallD = lw_stall || mdu_hold;
  assign StallE = mdu_hold;
  assign FlushE = (lw_stall || PCSrcE) && !mdu_hold;
  assign FlushD = PCSrcE && !mdu_hold;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((FlushD || FlushE) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MduBusy    = (state_q == BUSY);
  assign MduTimeout = timeout_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl: a cycle-level reference model
// queues expected outputs, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int TO    = 64;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk, rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MduStartE, MduDoneE;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, MduBusy, MduTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDoneE(MduDoneE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .MduBusy(MduBusy), .MduTimeout(MduTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct {
    int fa, fb, sf, sd, se, fd, fe, busy, to, sc, fc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_busy;
  bit m_to;
  int m_bcyc, m_sc, m_fc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_bcyc = 0; m_sc = 0; m_fc = 0;
  endtask

  // Inputs are already applied; queue this cycle's expectation, advance the model, then clock.
  task automatic step();
    exp_t e;
    bit lw, hold;
    lw   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    hold = m_busy ? !MduDoneE : MduStartE;
    e.fa = ref_fwd(Rs1E);
    e.fb = ref_fwd(Rs2E);
    e.sf = int'(lw || hold);
    e.sd = e.sf;
    e.se = int'(hold);
    e.fd = int'(PCSrcE && !hold);
    e.fe = int'((lw || PCSrcE) && !hold);
    e.busy = int'(m_busy);
    e.to = int'(m_to);
    e.sc = m_sc;
    e.fc = m_fc;
    q.push_back(e);
    if (e.sf != 0 && m_sc < SAT) m_sc++;
    if ((e.fd != 0 || e.fe != 0) && m_fc < SAT) m_fc++;
    if (m_busy) begin
      if (MduDoneE) begin
        m_busy = 0; m_bcyc = 0;
      end else begin
        m_bcyc++;
        if (m_bcyc >= TO) m_to = 1;
      end
    end else if (MduStartE) begin
      m_busy = 1; m_bcyc = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MduStartE = 0; MduDoneE = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ForwardAE", int'(ForwardAE), e.fa);
        check("ForwardBE", int'(ForwardBE), e.fb);
        check("StallF", int'(StallF), e.sf);
        check("StallD", int'(StallD), e.sd);
        check("StallE", int'(StallE), e.se);
        check("FlushD", int'(FlushD), e.fd);
        check("FlushE", int'(FlushE), e.fe);
        check("MduBusy", int'(MduBusy), e.busy);
        check("MduTimeout", int'(MduTimeout), e.to);
        check("StallCount", int'(StallCount), e.sc);
        check("FlushCount", int'(FlushCount), e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    check("rst_MduBusy", int'(MduBusy), 0);
    check("rst_StallF", int'(StallF), 0);
    check("rst_MduTimeout", int'(MduTimeout), 0);
    check("rst_StallCount", int'(StallCount), 0);
    check("rst_FlushCount", int'(FlushCount), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding priority
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1; step();
    RegWriteM = 0; step();
    RdM = 0; RdW = 0; RegWriteM = 1; step();
    clear_inputs();

    // Load-use then release
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; step();
    RdE = 0; step();
    clear_inputs();

    // Taken branch
    PCSrcE = 1; step();
    PCSrcE = 0; step();

    // MDU op: start at cycle 0, done at cycle 4
    MduStartE = 1;
    repeat (4) step();
    MduDoneE = 1; step();
    MduDoneE = 0; MduStartE = 0; step();

    // Masking of branch and load-use while busy
    MduStartE = 1; step();
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    repeat (2) step();
    MduDoneE = 1; step();
    clear_inputs(); step();

    // Watchdog: long busy period, flag survives completion
    MduStartE = 1;
    repeat (TO + 6) step();
    MduDoneE = 1; step();
    clear_inputs();
    repeat (2) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      if (m_busy) begin
        MduStartE = 1;
        MduDoneE  = ($urandom_range(0, 2) == 0);
      end else begin
        MduStartE = ($urandom_range(0, 5) == 0);
        MduDoneE  = 0;
      end
      step();
    end
    clear_inputs();
    if (m_busy) begin
      MduStartE = 1; MduDoneE = 1; step();
      clear_inputs();
    end

    // Counter saturation
    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
    repeat (300) step();
    clear_inputs();
    step();

    // Asynchronous reset in the middle of a busy period
    MduStartE = 1;
    repeat (4) step();
    MduStartE = 0;
    #2;
    check("pre_rst_StallE", int'(StallE), 1);
    check("pre_rst_MduBusy", int'(MduBusy), 1);
    check("pre_rst_MduTimeout", int'(MduTimeout), int'(m_to));
    rst = 1'b1;
    #1;
    check("arst_MduBusy", int'(MduBusy), 0);
    check("arst_StallE", int'(StallE), 0);
    check("arst_StallF", int'(StallF), 0);
    check("arst_MduTimeout", int'(MduTimeout), 0);
    check("arst_StallCount", int'(StallCount), 0);
    check("arst_FlushCount", int'(FlushCount), 0);
    model_reset();
    q.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    PCSrcE = 1; step();
    clear_inputs();
    MduStartE = 1; step();
    MduDoneE = 1; step();
    clear_inputs(); step();

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
